// File: rtl/fir_xifu_scoreboard.sv
`default_nettype none
// ============================================================================
// Module      : fir_xifu_scoreboard
// Description : In-flight instruction table and issue gate for the FIR XIFU
//               coprocessor (hazard/duplicate/full stalls, commit tracking).
// Revision    : 1.0 - initial release
// ============================================================================
module fir_xifu_scoreboard #(
    parameter  int NB_REGS = 4,
    parameter  int DEPTH   = 4,
    parameter  int ID_W    = 4,
    localparam int CNT_W   = $clog2(DEPTH + 1)
) (
    input  logic               clk_i,
    input  logic               rst_ni,
    input  logic               clear_i,
    input  logic               issue_valid_i,
    input  logic [ID_W-1:0]    issue_id_i,
    input  logic [NB_REGS-1:0] issue_rs_mask_i,
    input  logic [NB_REGS-1:0] issue_rd_mask_i,
    output logic               issue_ready_o,
    input  logic               commit_valid_i,
    input  logic [ID_W-1:0]    commit_id_i,
    input  logic               commit_kill_i,
    input  logic               retire_valid_i,
    input  logic [ID_W-1:0]    retire_id_i,
    input  logic [ID_W-1:0]    wb_query_id_i,
    output logic               wb_found_o,
    output logic               wb_committed_o,
    output logic [CNT_W-1:0]   count_o,
    output logic               busy_o,
    output logic               err_o
);

    logic [DEPTH-1:0]   r_valid;
    logic [DEPTH-1:0]   r_committed;
    logic [ID_W-1:0]    r_id [DEPTH];
    logic [NB_REGS-1:0] r_rd [DEPTH];
    logic               r_err;

    logic [NB_REGS-1:0] w_pend;
    logic [CNT_W-1:0]   w_count;
    logic [DEPTH-1:0]   w_alloc_oh;
    logic               w_taken;
    logic               w_dup;
    logic               w_found;
    logic               w_wb_comm;
    logic               w_ret_hit;
    logic               w_ret_bad;
    logic               w_full;
    logic               w_fire;
    logic               w_commit;
    logic               w_kill;
    logic               w_new_killed;
    logic               w_new_committed;

    assign w_commit        = commit_valid_i & ~commit_kill_i;
    assign w_kill          = commit_valid_i &  commit_kill_i;
    assign w_new_killed    = w_kill   & (commit_id_i == issue_id_i);
    assign w_new_committed = w_commit & (commit_id_i == issue_id_i);

    always_comb begin
        w_pend     = '0;
        w_count    = '0;
        w_dup      = 1'b0;
        w_found    = 1'b0;
        w_wb_comm  = 1'b0;
        w_ret_hit  = 1'b0;
        w_ret_bad  = 1'b0;
        w_alloc_oh = '0;
        w_taken    = 1'b0;
        for (int i = 0; i < DEPTH; i++) begin
            if (r_valid[i]) begin
                w_pend  = w_pend | r_rd[i];
                w_count = w_count + CNT_W'(1);
                if (r_id[i] == issue_id_i)
                    w_dup = 1'b1;
                if (r_id[i] == wb_query_id_i) begin
                    w_found   = 1'b1;
                    w_wb_comm = r_committed[i];
                end
                if (r_id[i] == retire_id_i) begin
                    w_ret_hit = 1'b1;
                    // A commit arriving alongside the retire makes it legal.
                    if (!r_committed[i] && !(w_commit && commit_id_i == retire_id_i))
                        w_ret_bad = 1'b1;
                end
            end else if (!w_taken) begin
                w_alloc_oh[i] = 1'b1;
                w_taken       = 1'b1;
            end
        end
    end

    assign w_full        = (w_count == CNT_W'(DEPTH));
    assign issue_ready_o = ~w_full & ~w_dup &
                           (((issue_rs_mask_i | issue_rd_mask_i) & w_pend) == '0);
    assign w_fire        = issue_valid_i & issue_ready_o;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_valid     <= '0;
            r_committed <= '0;
            r_err       <= 1'b0;
            for (int i = 0; i < DEPTH; i++) begin
                r_id[i] <= '0;
                r_rd[i] <= '0;
            end
        end else if (clear_i) begin
            r_valid <= '0;
        end else begin
            if (retire_valid_i && (!w_ret_hit || w_ret_bad))
                r_err <= 1'b1;
            for (int i = 0; i < DEPTH; i++) begin
                if (r_valid[i]) begin
                    if ((w_kill && r_id[i] == commit_id_i) ||
                        (retire_valid_i && r_id[i] == retire_id_i))
                        r_valid[i] <= 1'b0;
                    else if (w_commit && r_id[i] == commit_id_i)
                        r_committed[i] <= 1'b1;
                end else if (w_fire && w_alloc_oh[i] && !w_new_killed) begin
                    r_valid[i]     <= 1'b1;
                    r_id[i]        <= issue_id_i;
                    r_rd[i]        <= issue_rd_mask_i;
                    r_committed[i] <= w_new_committed;
                end
            end
        end
    end

    assign count_o        = w_count;
    assign busy_o         = (w_count != '0);
    assign err_o          = r_err;
    assign wb_found_o     = w_found;
    assign wb_committed_o = w_wb_comm;

endmodule
`default_nettype wire

// File: tb/tb_fir_xifu_scoreboard.sv
`default_nettype none
// ============================================================================
// Module      : tb_fir_xifu_scoreboard
// Description : Directed plus randomized bench against a queue-based model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_fir_xifu_scoreboard;
    localparam int NB_REGS = 4;
    localparam int DEPTH   = 4;
    localparam int ID_W    = 4;
    localparam int CNT_W   = $clog2(DEPTH + 1);

    logic               clk = 1'b0;
    logic               rst_ni;
    logic               clear_i;
    logic               issue_valid_i;
    logic [ID_W-1:0]    issue_id_i;
    logic [NB_REGS-1:0] issue_rs_mask_i;
    logic [NB_REGS-1:0] issue_rd_mask_i;
    logic               issue_ready_o;
    logic               commit_valid_i;
    logic [ID_W-1:0]    commit_id_i;
    logic               commit_kill_i;
    logic               retire_valid_i;
    logic [ID_W-1:0]    retire_id_i;
    logic [ID_W-1:0]    wb_query_id_i;
    logic               wb_found_o;
    logic               wb_committed_o;
    logic [CNT_W-1:0]   count_o;
    logic               busy_o;
    logic               err_o;

    always #5 clk = ~clk;

    fir_xifu_scoreboard #(.NB_REGS(NB_REGS), .DEPTH(DEPTH), .ID_W(ID_W)) u_dut (
        .clk_i(clk), .rst_ni(rst_ni), .clear_i(clear_i),
        .issue_valid_i(issue_valid_i), .issue_id_i(issue_id_i),
        .issue_rs_mask_i(issue_rs_mask_i), .issue_rd_mask_i(issue_rd_mask_i),
        .issue_ready_o(issue_ready_o),
        .commit_valid_i(commit_valid_i), .commit_id_i(commit_id_i),
        .commit_kill_i(commit_kill_i),
        .retire_valid_i(retire_valid_i), .retire_id_i(retire_id_i),
        .wb_query_id_i(wb_query_id_i), .wb_found_o(wb_found_o),
        .wb_committed_o(wb_committed_o), .count_o(count_o),
        .busy_o(busy_o), .err_o(err_o)
    );

    typedef struct {
        logic [ID_W-1:0]    id;
        logic [NB_REGS-1:0] rd;
        bit                 committed;
    } ent_t;

    ent_t mq[$];
    bit   m_err;
    int   n_cmp = 0;
    int   n_err = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    function automatic int m_find(input logic [ID_W-1:0] id);
        foreach (mq[i]) if (mq[i].id == id) return i;
        return -1;
    endfunction

    function automatic bit m_ready(input logic [ID_W-1:0] id,
                                   input logic [NB_REGS-1:0] rs,
                                   input logic [NB_REGS-1:0] rd);
        logic [NB_REGS-1:0] pend = '0;
        foreach (mq[i]) pend |= mq[i].rd;
        return (mq.size() < DEPTH) && (m_find(id) < 0) && (((rs | rd) & pend) == '0);
    endfunction

    // Drive one cycle of inputs at the falling edge, check outputs, then
    // advance the model across the rising edge.
    task automatic step(input bit iv, input int iid, input int rs, input int rd,
                        input bit cv, input int cid, input bit ck,
                        input bit rv, input int rid, input bit cl, input int qid);
        bit   rdy, fire, cnow;
        int   k;
        ent_t nq[$];
        issue_valid_i   = iv;
        issue_id_i      = ID_W'(iid);
        issue_rs_mask_i = NB_REGS'(rs);
        issue_rd_mask_i = NB_REGS'(rd);
        commit_valid_i  = cv;
        commit_id_i     = ID_W'(cid);
        commit_kill_i   = ck;
        retire_valid_i  = rv;
        retire_id_i     = ID_W'(rid);
        clear_i         = cl;
        wb_query_id_i   = ID_W'(qid);
        #1;
        rdy = m_ready(issue_id_i, issue_rs_mask_i, issue_rd_mask_i);
        k   = m_find(wb_query_id_i);
        check("issue_ready", 32'(issue_ready_o), 32'(rdy));
        check("count",       32'(count_o),       32'(mq.size()));
        check("busy",        32'(busy_o),        32'(mq.size() != 0));
        check("err",         32'(err_o),         32'(m_err));
        check("wb_found",    32'(wb_found_o),    32'(k >= 0));
        check("wb_committed", 32'(wb_committed_o), 32'((k >= 0) && mq[k].committed));
        @(posedge clk);
        if (cl) begin
            mq.delete();
        end else begin
            fire = iv && rdy;
            if (rv) begin
                k = m_find(retire_id_i);
                if (k < 0)
                    m_err = 1'b1;
                else if (!(mq[k].committed || (cv && !ck && commit_id_i == retire_id_i)))
                    m_err = 1'b1;
            end
            nq.delete();
            foreach (mq[i]) begin
                ent_t e = mq[i];
                if (cv && ck && e.id == commit_id_i) continue;
                if (rv && e.id == retire_id_i) continue;
                if (cv && !ck && e.id == commit_id_i) e.committed = 1'b1;
                nq.push_back(e);
            end
            if (fire && !(cv && ck && commit_id_i == issue_id_i)) begin
                ent_t e;
                e.id        = issue_id_i;
                e.rd        = issue_rd_mask_i;
                e.committed = cv && !ck && (commit_id_i == issue_id_i);
                nq.push_back(e);
            end
            mq = nq;
        end
        @(negedge clk);
    endtask

    task automatic idle(input int qid);
        step(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, qid);
    endtask

    task automatic do_reset();
        rst_ni = 1'b0;
        #1;
        mq.delete();
        m_err = 1'b0;
        check("rst_count", 32'(count_o), 32'd0);
        check("rst_err",   32'(err_o),   32'd0);
        check("rst_busy",  32'(busy_o),  32'd0);
        @(negedge clk);
        rst_ni = 1'b1;
    endtask

    initial begin
        int qid, cid, rid;
        bit cv, rv;
        rst_ni = 1'b0; clear_i = 0; issue_valid_i = 0; issue_id_i = 0;
        issue_rs_mask_i = 0; issue_rd_mask_i = 0; commit_valid_i = 0;
        commit_id_i = 0; commit_kill_i = 0; retire_valid_i = 0;
        retire_id_i = 0; wb_query_id_i = 0;
        repeat (2) @(negedge clk);
        do_reset();
        check("rst_ready", 32'(issue_ready_o), 32'd1);

        // RAW stall until producer commits and retires
        step(1, 3, 0, 1, 0, 0, 0, 0, 0, 0, 3);
        step(1, 5, 1, 0, 0, 0, 0, 0, 0, 0, 3);
        step(1, 5, 1, 0, 1, 3, 0, 0, 0, 0, 3);
        step(1, 5, 1, 0, 0, 0, 0, 1, 3, 0, 3);
        step(1, 5, 1, 0, 0, 0, 0, 0, 0, 0, 5);
        step(0, 0, 0, 0, 1, 5, 0, 1, 5, 0, 5);

        // Full table, then a kill frees a slot
        for (int i = 0; i < 4; i++) step(1, i, 0, 1 << i, 0, 0, 0, 0, 0, 0, i);
        step(1, 4, 0, 0, 0, 0, 0, 0, 0, 0, 2);
        step(1, 4, 0, 0, 1, 2, 1, 0, 0, 0, 2);
        step(1, 4, 0, 0, 0, 0, 0, 0, 0, 0, 2);
        step(0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 4);

        // Same-cycle issue with commit, then with kill
        step(1, 7, 0, 1, 1, 7, 0, 0, 0, 0, 7);
        idle(7);
        step(0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 7);
        step(1, 7, 0, 1, 1, 7, 1, 0, 0, 0, 7);
        idle(7);

        // Duplicate ID stall with disjoint masks
        step(1, 9, 0, 1, 0, 0, 0, 0, 0, 0, 9);
        step(1, 9, 0, 2, 0, 0, 0, 0, 0, 0, 9);
        step(1, 9, 0, 2, 1, 9, 0, 1, 9, 0, 9);
        step(1, 9, 0, 2, 0, 0, 0, 0, 0, 0, 9);
        step(0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 9);

        // Clear wins over a concurrent issue
        for (int i = 0; i < 3; i++) step(1, 10 + i, 0, 1 << i, 0, 0, 0, 0, 0, 0, 10);
        step(1, 13, 0, 8, 0, 0, 0, 0, 0, 1, 13);
        idle(13);

        // Uncommitted retire raises a sticky error that survives clear
        step(1, 6, 0, 1, 0, 0, 0, 0, 0, 0, 6);
        step(0, 0, 0, 0, 0, 0, 0, 1, 6, 0, 6);
        idle(6);
        step(0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 6);
        idle(6);
        check("err_sticky", 32'(err_o), 32'd1);
        do_reset();
        idle(0);

        for (int n = 0; n < 3000; n++) begin
            qid = (mq.size() != 0 && $urandom_range(0, 9) < 7) ? int'(mq[$urandom_range(0, mq.size() - 1)].id)
                                                               : int'($urandom_range(0, 15));
            cv  = ($urandom_range(0, 9) < 4);
            cid = (mq.size() != 0 && $urandom_range(0, 9) < 8) ? int'(mq[$urandom_range(0, mq.size() - 1)].id)
                                                               : int'($urandom_range(0, 15));
            rv  = ($urandom_range(0, 9) < 3);
            rid = $urandom_range(0, 15);
            if ($urandom_range(0, 19) != 0)
                foreach (mq[i]) if (mq[i].committed) rid = int'(mq[i].id);
            step($urandom_range(0, 2) != 0, $urandom_range(0, 15),
                 $urandom & $urandom & 15, $urandom & $urandom & 15,
                 cv, cid, $urandom_range(0, 4) == 0, rv, rid,
                 $urandom_range(0, 63) == 0, qid);
            if ($urandom_range(0, 499) == 0) do_reset();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
`default_nettype wire
